// File: rtl/bus_requester.sv
// Bus requester: req/gnt handshake, then a len-word incrementing burst.
// Define BUS_REQUESTER_TIMEOUT_EN to abort with err after TIMEOUT grant-wait cycles.
module bus_requester #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        len,
  input  logic [DATA_W-1:0] base,
  input  logic              gnt,
  output logic              req,
  output logic              bus_valid,
  output logic [DATA_W-1:0] bus_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, REQ, XFER, REL} state_t;

  state_t            state, state_n;
  logic [2:0]        len_q, len_n;
  logic [2:0]        cnt, cnt_n;
  logic [DATA_W-1:0] data_q, data_n;
  logic [DATA_W-1:0] bus_data_n;
  logic              req_n, valid_n, busy_n, done_n;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("bus_requester: TIMEOUT must be 1..255");
  end

`ifdef BUS_REQUESTER_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wcnt, wcnt_n;
  logic       err_q, err_n;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    len_n      = len_q;
    cnt_n      = cnt;
    data_n     = data_q;
    bus_data_n = bus_data;
    req_n      = req;
    valid_n    = 1'b0;
    busy_n     = busy;
    done_n     = 1'b0;
`ifdef BUS_REQUESTER_TIMEOUT_EN
    wcnt_n     = wcnt;
    err_n      = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (start && len != 3'd0) begin
          state_n = REQ;
          len_n   = len;
          data_n  = base;
          cnt_n   = '0;
          req_n   = 1'b1;
          busy_n  = 1'b1;
`ifdef BUS_REQUESTER_TIMEOUT_EN
          wcnt_n  = '0;
`endif
        end
      end
      REQ: begin
        if (gnt) begin
          state_n    = XFER;
          valid_n    = 1'b1;
          bus_data_n = data_q;
          data_n     = data_q + DATA_W'(1);
          cnt_n      = cnt + 3'd1;
        end
`ifdef BUS_REQUESTER_TIMEOUT_EN
        else if (wcnt == WAIT_LAST) begin
          state_n = REL;
          req_n   = 1'b0;
          done_n  = 1'b1;
          err_n   = 1'b1;
        end else begin
          wcnt_n  = wcnt + 8'd1;
        end
`endif
      end
      XFER: begin
        // last word leaves regardless of gnt; stalls only hold
        if (cnt == len_q) begin
          state_n = REL;
          req_n   = 1'b0;
          done_n  = 1'b1;
        end else if (gnt) begin
          valid_n    = 1'b1;
          bus_data_n = data_q;
          data_n     = data_q + DATA_W'(1);
          cnt_n      = cnt + 3'd1;
        end
      end
      REL: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len_q     <= '0;
      cnt       <= '0;
      data_q    <= '0;
      bus_data  <= '0;
      req       <= 1'b0;
      bus_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef BUS_REQUESTER_TIMEOUT_EN
      wcnt      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      len_q     <= len_n;
      cnt       <= cnt_n;
      data_q    <= data_n;
      bus_data  <= bus_data_n;
      req       <= req_n;
      bus_valid <= valid_n;
      busy      <= busy_n;
      done      <= done_n;
`ifdef BUS_REQUESTER_TIMEOUT_EN
      wcnt      <= wcnt_n;
      err_q     <= err_n;
`endif
    end
  end

endmodule

// File: tb/tb_bus_requester.sv
// Self-checking bench for bus_requester: directed and random bursts
// against a transaction-level model of the expected word stream.
module tb_bus_requester;
  localparam int DW = 8;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst, start, gnt;
  logic [2:0]    len;
  logic [DW-1:0] base;
  logic          req, bus_valid, busy, done, err;
  logic [DW-1:0] bus_data;

  int            vectors = 0;
  int            miscompares = 0;
  logic [DW-1:0] last_data;

  always #5 clk = ~clk;

  bus_requester #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .base(base),
    .gnt(gnt), .req(req), .bus_valid(bus_valid), .bus_data(bus_data),
    .busy(busy), .done(done), .err(err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // packed as {req, bus_valid, busy, done, err, bus_data}
  task automatic chk_out(input string tag, input logic r, input logic v,
                         input logic b, input logic d, input logic e,
                         input logic [DW-1:0] data);
    chk(tag, 32'({req, bus_valid, busy, done, err, bus_data}),
        32'({r, v, b, d, e, data}));
  endtask

  // mode 0: gnt held, 1: random stalls, 2: two-cycle drop after word 2
  task automatic txn(input int n, input logic [DW-1:0] b, input int wait_c,
                     input int mode, input bit mid);
    int k;
    int drop;
    bit dropped;
    bit g;
    int req_hi;
    logic [DW-1:0] w;
    start = 1'b1; len = 3'(n); base = b; gnt = 1'b0;
    tick;
    start = 1'b0; len = 3'($urandom); base = DW'($urandom);
    chk_out("req_rise", 1, 0, 1, 0, 0, last_data);
    for (int i = 0; i < wait_c; i++) begin
      tick;
      chk_out("grant_wait", 1, 0, 1, 0, 0, last_data);
    end
    gnt = 1'b1; k = 0; drop = 0; dropped = 0;
    req_hi = int'(req);
    while (k < n) begin
      g = gnt;
      tick;
      start = 1'b0;
      req_hi += int'(req);
      if (g) begin
        w = b + DW'(k);
        k++;
        last_data = w;
        chk_out("word", 1, 1, 1, 0, 0, w);
      end else begin
        chk_out("stall", 1, 0, 1, 0, 0, last_data);
      end
      if (mode == 2 && k == 2 && !dropped) begin
        drop = 2;
        dropped = 1;
      end
      if (drop > 0) begin
        gnt = 1'b0;
        drop--;
      end else if (mode == 1) begin
        gnt = ($urandom_range(0, 3) != 0);
      end else begin
        gnt = 1'b1;
      end
      if (mid && k == 1) begin
        start = 1'b1; len = 3'd7; base = DW'($urandom);
      end
    end
    tick;
    start = 1'b0;
    req_hi += int'(req);
    chk_out("release", 0, 0, 1, 1, 0, last_data);
    if (mode == 0) chk("req_cycles", 32'(req_hi), 32'(n + 1));
    gnt = 1'b0;
    tick;
    chk_out("back_idle", 0, 0, 0, 0, 0, last_data);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; gnt = 1'b0; len = '0; base = '0;
    last_data = '0;
    tick;
    tick;
    rst = 1'b0;
    chk_out("reset", 0, 0, 0, 0, 0, 0);

    start = 1'b1; len = 3'd0; base = 8'h55;
    tick;
    start = 1'b0;
    chk_out("len0_ignored", 0, 0, 0, 0, 0, last_data);
    tick;
    chk_out("len0_no_done", 0, 0, 0, 0, 0, last_data);

    txn(3, 8'hFE, 0, 0, 0);
    txn(4, 8'h10, 0, 2, 0);

    start = 1'b1; len = 3'd2; base = DW'($urandom); gnt = 1'b0;
    tick;
    start = 1'b0;
    chk_out("to_req", 1, 0, 1, 0, 0, last_data);
`ifdef BUS_REQUESTER_TIMEOUT_EN
    for (int i = 1; i < TO; i++) begin
      tick;
      chk_out("to_wait", 1, 0, 1, 0, 0, last_data);
    end
    tick;
    chk_out("to_abort", 0, 0, 1, 1, 1, last_data);
    tick;
    chk_out("to_idle", 0, 0, 0, 0, 0, last_data);
`else
    for (int i = 0; i < 2 * TO; i++) begin
      tick;
      chk_out("no_to_wait", 1, 0, 1, 0, 0, last_data);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    last_data = '0;
    chk_out("reset_in_req", 0, 0, 0, 0, 0, 0);
`endif

    start = 1'b1; len = 3'd5; base = 8'hA0; gnt = 1'b1;
    tick;
    start = 1'b0;
    chk_out("rst_txn_req", 1, 0, 1, 0, 0, last_data);
    tick;
    chk_out("rst_txn_w0", 1, 1, 1, 0, 0, 8'hA0);
    tick;
    chk_out("rst_txn_w1", 1, 1, 1, 0, 0, 8'hA1);
    rst = 1'b1;
    tick;
    rst = 1'b0; gnt = 1'b0;
    last_data = '0;
    chk_out("rst_mid_xfer", 0, 0, 0, 0, 0, 0);
    tick;
    chk_out("rst_no_done", 0, 0, 0, 0, 0, 0);

    txn(5, 8'h3C, 1, 0, 0);
    txn(7, 8'hF9, 1, 0, 1);
    txn(5, 8'h80, 2, 1, 1);

    for (int t = 0; t < 20; t++) begin
      txn($urandom_range(1, 7), DW'($urandom), $urandom_range(0, 3),
          $urandom_range(0, 1), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
